// File: rtl/ustc_psum_acc_pp.sv
`default_nettype none
// ustc_psum_acc_pp: ping-pong partial-sum tile buffer. One bank collects
// overwrite/accumulate lane writes while the other drains row by row.
module ustc_psum_acc_pp #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int NUM_IN  = 32,
    parameter int DW_DATA = 8,
    parameter int DW_ACC  = 16,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_CTRL = 4,
    parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL,
    parameter int DW_OUT  = N * DW_ACC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW_COL-1:0]        col_i,
    input  logic [NUM_IN*DW_LINE-1:0] in_i,
    input  logic                     acc_en_i,
    input  logic                     swap_i,
    output logic                     swap_ready_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DW_ROW-1:0]        out_row_o,
    output logic                     out_last_o,
    output logic [DW_OUT-1:0]        out_o
);

    localparam logic [DW_ROW:0]   M_LIM    = (DW_ROW+1)'(M);
    localparam logic [DW_COL:0]   N_LIM    = (DW_COL+1)'(N);
    localparam logic [DW_ROW-1:0] LAST_ROW = DW_ROW'(M-1);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_DRAIN = 1'b1} state_t;

    state_t            state_q, state_d;
    logic              fill_q, fill_d;
    logic [DW_ROW-1:0] row_q, row_d;
    logic [DW_ACC-1:0] bank_q [2][M][N];

    logic              drain_sel;
    logic              col_ok;
    logic              row_last;
    logic              hs;
    logic [DW_ACC-1:0] wr_val [M];
    logic              wr_hit [M];

    logic [DW_LINE-1:0] lane;
    logic [DW_DATA-1:0] lane_data;
    logic [DW_ROW-1:0]  lane_row;
    logic [DW_CTRL-1:0] lane_ctrl;
    logic [DW_ACC-1:0]  lane_ext;
    logic               unused_ctrl;

    assign drain_sel = ~fill_q;
    assign col_ok    = ({1'b0, col_i} < N_LIM);
    assign row_last  = (row_q == LAST_ROW);
    assign hs        = (state_q == S_DRAIN) && out_ready_i;

    // Lanes are folded in index order, so in overwrite mode the highest
    // active lane naturally wins and in accumulate mode all lanes sum.
    always_comb begin
        lane        = '0;
        lane_data   = '0;
        lane_row    = '0;
        lane_ctrl   = '0;
        lane_ext    = '0;
        unused_ctrl = 1'b0;
        for (int r = 0; r < M; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = bank_q[fill_q][r][col_i];
        end
        for (int i = 0; i < NUM_IN; i++) begin
            lane        = in_i[i*DW_LINE +: DW_LINE];
            lane_data   = lane[DW_DATA-1:0];
            lane_row    = lane[DW_DATA +: DW_ROW];
            lane_ctrl   = lane[DW_DATA+DW_ROW +: DW_CTRL];
            lane_ext    = DW_ACC'($signed(lane_data));
            unused_ctrl = ^{unused_ctrl, lane_ctrl};
            if (lane_ctrl[DW_CTRL-2] && ({1'b0, lane_row} < M_LIM)) begin
                wr_hit[lane_row] = 1'b1;
                wr_val[lane_row] = acc_en_i ? (wr_val[lane_row] + lane_ext) : lane_ext;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        row_d   = row_q;
        case (state_q)
            S_IDLE: begin
                if (swap_i) begin
                    state_d = S_DRAIN;
                    fill_d  = ~fill_q;
                    row_d   = '0;
                end
            end
            S_DRAIN: begin
                if (out_ready_i) begin
                    if (row_last) begin
                        state_d = S_IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + DW_ROW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fill_q  <= 1'b0;
            row_q   <= '0;
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < N; c++)
                        bank_q[b][r][c] <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            row_q   <= row_d;
            if (col_ok) begin
                for (int r = 0; r < M; r++)
                    if (wr_hit[r])
                        bank_q[fill_q][r][col_i] <= wr_val[r];
            end
            // Fill and drain banks always differ, so clearing never races a write.
            if (hs) begin
                for (int c = 0; c < N; c++)
                    bank_q[drain_sel][row_q][c] <= '0;
            end
        end
    end

    assign swap_ready_o = (state_q == S_IDLE);
    assign out_valid_o  = (state_q == S_DRAIN);
    assign out_row_o    = row_q;
    assign out_last_o   = (state_q == S_DRAIN) && row_last;

    generate
        for (genvar j = 0; j < N; j++) begin : g_out
            assign out_o[j*DW_ACC +: DW_ACC] = bank_q[drain_sel][row_q][j];
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/ustc_psum_acc_pp.md
Name: ustc_psum_acc_pp

Overview:
Next-generation partial-sum buffer for the unstructured sparse tensor core. It collects NUM_IN scattered {ctrl,row,data} lanes into an M x N tile and, selected per cycle, either overwrites entries or accumulates into them at DW_ACC width. Two banks work in ping-pong, so one tile fills while the previous tile drains row by row over a valid/ready stream. It sits between the sparse PE array output lanes and the result writeback path.

Parameters:
M, 16, tile rows = rows drained per tile
N, 16, tile columns = output lanes per row
NUM_IN, 32, input lanes per cycle
DW_DATA, 8, input data width, signed
DW_ACC, 16, accumulator/output element width, signed, DW_ACC >= DW_DATA
DW_ROW, 4, row index width, 2^DW_ROW >= M
DW_COL, 4, column index width, 2^DW_COL >= N
DW_CTRL, 4, lane control width; bit DW_CTRL-2 = lane valid, others ignored
DW_LINE, DW_DATA+DW_ROW+DW_CTRL, lane width, packed {ctrl,row,data}, data in LSBs
DW_OUT, N*DW_ACC, output row width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
col  in  DW_COL  column written by all lanes this cycle
in  in  NUM_IN*DW_LINE  lane i = in[i*DW_LINE +: DW_LINE]
acc_en  in  1  1 = accumulate into entry, 0 = overwrite entry
swap  in  1  request: close the fill tile and start draining it
swap_ready  out  1  1 when the drain bank is idle, so a swap is accepted this cycle
out_valid  out  1  row data valid
out_ready  in  1  downstream accepts the row
out_row  out  DW_ROW  index of the row being presented
out_last  out  1  high with row M-1
out  out  DW_OUT  element j = out[j*DW_ACC +: DW_ACC] = tile[out_row][j]

Behaviour:
- Reset, at the next clk edge: both banks = 0; fill bank = 0; drain idle; out_valid = 0; out_row = 0; out_last = 0; swap_ready = 1. Reset mid-drain aborts the drain, and both banks are zeroed.
- Writes go only to the fill bank. A lane is active when ctrl[DW_CTRL-2] = 1. Active lanes with row >= M, or cycles with col >= N, are dropped silently.
- Overwrite (acc_en = 0): entry <= sign_ext(data). If several active lanes hit the same row, the highest lane index wins.
- Accumulate (acc_en = 0/1 = 1): entry <= entry + the sum of sign_ext(data) over all active lanes hitting that row, in a single cycle. The result wraps modulo 2^DW_ACC; there is no saturation.
- Fill-side writes continue in every cycle, including during a drain.
- Swap is accepted when swap = 1 and swap_ready = 1. Writes in the accept cycle land in the old fill bank, which becomes the drain bank. On the next cycle the other (already-zero) bank is the fill bank.
- Swap with swap_ready = 0 is ignored with no side effects. The requester must hold swap.
- Drain FSM:
  - IDLE -> DRAIN on an accepted swap.
  - In DRAIN: out_valid = 1, and out is a combinational read of drain_bank[out_row].
  - A handshake occurs when out_valid and out_ready are both 1. On a handshake, that row of the drain bank is cleared to 0 and out_row increments.
  - On the handshake with out_last (row M-1): return to IDLE, out_valid = 0, out_row = 0.
  - While out_valid = 1 and out_ready = 0: out, out_row and out_last hold stable.
- swap_ready = (state == IDLE), registered. A swap can be accepted in the cycle right after the last-row handshake.
- Latency: the first row is valid 1 cycle after swap acceptance. With out_ready held high, a drain takes exactly M cycles.
- Throughput: a new tile every M+1 cycles at most.

Test Plan:
1. Reset, then overwrite: col=3; lane0 {valid,row=2,data=0x7F}, lane1 {valid,row=2,data=0x05}; swap; ready=1 -> out_row=2 shows element3=0x0005 (lane1 wins), all other elements 0; 16 beats; out_last on beat 16.
2. Accumulate: acc_en=1, col=0; 3 cycles of lane0 row1 data=-1 (0xFF) plus lane5 row1 data=2; swap -> row1 element0 = 0x0003. Add an overflow case: 300 writes of +127 into one entry -> 38100 mod 65536 as signed = 0x94D4.
3. Backpressure: out_ready toggling 1,0,0,1 -> out and out_row stable while stalled; rows 0..15 each appear exactly once, in order.
4. Ping-pong overlap: fill tile B while tile A drains with ready=1. A swap during the drain -> swap ignored and swap_ready=0. A swap in the cycle after out_last -> accepted; tile B contents correct and untouched by A's clearing.
5. Boundaries: row=15 with M=12 dropped; col>=N dropped; swap-cycle writes appear in the drained tile; tile drained twice gives all zeros the second time.
6. Reset asserted at drain row 7 -> out_valid=0 next cycle, swap_ready=1, and a subsequent swap drains all zeros.
